// File: rtl/pwm_multi_wb.sv
// Multi-channel PWM peripheral on a Wishbone slave port: shared prescaler and period counter,
// double-buffered per-channel duty compare, and a per-period status flag with level interrupt.
module pwm_multi_wb #(
    parameter int NUM_CH  = 3,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    output logic [NUM_CH-1:0] o_pwm,
    output logic              o_irq,
    input  logic [31:0]       i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack
);

    localparam logic [4:0] IDX_CTRL  = 5'd0;
    localparam logic [4:0] IDX_PRESC = 5'd1;
    localparam logic [4:0] IDX_TOP   = 5'd2;
    localparam logic [4:0] IDX_STAT  = 5'd3;

    logic               en_q, en_d, inv_q, inv_d, ie_q, ie_d, auto_q, auto_d, upd_q, upd_d;
    logic [PRESC_W-1:0] presc_q, presc_d, psc_cnt_q, psc_cnt_d;
    logic [PWM_W-1:0]   top_q, top_d, cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [15:0]        pcnt_q, pcnt_d;
    logic [PWM_W-1:0]   shadow_q [NUM_CH];
    logic [PWM_W-1:0]   shadow_d [NUM_CH];
    logic [PWM_W-1:0]   active_q [NUM_CH];
    logic [PWM_W-1:0]   active_d [NUM_CH];
    logic [NUM_CH-1:0]  pwm_q, pwm_d;
    logic               ack_q;
    logic [31:0]        rdat_q, rdat_d;

    logic [4:0]  idx;
    logic        req, wr, tick, period_end;
    logic [31:0] lane_mask, rd_val, wr_val;
    logic        unused_ok;

    assign idx       = i_wb_adr[6:2];
    assign req       = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr        = req & i_wb_we;
    assign lane_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    // Byte-lane merge of the write data into the register's current readable value.
    assign wr_val    = (rd_val & ~lane_mask) | (i_wb_dat & lane_mask);
    assign unused_ok = ^{i_wb_adr[31:7], i_wb_adr[1:0], wr_val};

    // NOTE: every signal driven in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_val = '0;
        case (idx)
            IDX_CTRL:  rd_val[4:0] = {upd_q, auto_q, ie_q, inv_q, en_q};
            IDX_PRESC: rd_val[PRESC_W-1:0] = presc_q;
            IDX_TOP:   rd_val[PWM_W-1:0] = top_q;
            IDX_STAT:  rd_val = {pcnt_q, 15'd0, pend_q};
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (idx == 5'(4 + i)) rd_val[PWM_W-1:0] = shadow_q[i];
                end
            end
        endcase
    end

    always_comb begin
        tick       = 1'b0;
        period_end = 1'b0;
        psc_cnt_d  = psc_cnt_q;
        cnt_d      = cnt_q;
        if (!en_q) begin
            psc_cnt_d = '0;
            cnt_d     = '0;
        end else if (psc_cnt_q == '0) begin
            psc_cnt_d = presc_q;
            tick      = 1'b1;
        end else begin
            psc_cnt_d = psc_cnt_q - PRESC_W'(1);
        end
        // >= rather than == so a TOP lowered below the running count wraps on the next tick.
        if (tick) begin
            if (cnt_q >= top_q) begin
                cnt_d      = '0;
                period_end = 1'b1;
            end else begin
                cnt_d = cnt_q + PWM_W'(1);
            end
        end
    end

    always_comb begin
        en_d     = en_q;
        inv_d    = inv_q;
        ie_d     = ie_q;
        auto_d   = auto_q;
        upd_d    = upd_q;
        presc_d  = presc_q;
        top_d    = top_q;
        pend_d   = pend_q;
        pcnt_d   = pcnt_q;
        shadow_d = shadow_q;
        active_d = active_q;

        // Load uses the pre-write shadow; a same-cycle UPD write below re-arms the next load.
        if (period_end && (auto_q || upd_q)) begin
            active_d = shadow_q;
            upd_d    = 1'b0;
        end

        if (wr) begin
            case (idx)
                IDX_CTRL: begin
                    {auto_d, ie_d, inv_d, en_d} = wr_val[3:0];
                    if (i_wb_sel[0] && i_wb_dat[4]) upd_d = 1'b1;
                end
                IDX_PRESC: presc_d = wr_val[PRESC_W-1:0];
                IDX_TOP:   top_d = wr_val[PWM_W-1:0];
                IDX_STAT:  if (i_wb_sel[0] && i_wb_dat[0]) pend_d = 1'b0;
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx == 5'(4 + i)) shadow_d[i] = wr_val[PWM_W-1:0];
                    end
                end
            endcase
        end

        if (period_end) begin
            pend_d = 1'b1;
            pcnt_d = pcnt_q + 16'd1;
        end

        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = en_q ? ((cnt_q < active_q[i]) ^ inv_q) : inv_q;
        end

        rdat_d = req ? rd_val : rdat_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            en_q      <= 1'b0;
            inv_q     <= 1'b0;
            ie_q      <= 1'b0;
            auto_q    <= 1'b0;
            upd_q     <= 1'b0;
            presc_q   <= '0;
            top_q     <= '1;
            pend_q    <= 1'b0;
            pcnt_q    <= '0;
            psc_cnt_q <= '0;
            cnt_q     <= '0;
            // NOTE: the duty arrays are small flop banks, not RAM, so they take the async reset like any register.
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            pwm_q     <= '0;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
        end else begin
            en_q      <= en_d;
            inv_q     <= inv_d;
            ie_q      <= ie_d;
            auto_q    <= auto_d;
            upd_q     <= upd_d;
            presc_q   <= presc_d;
            top_q     <= top_d;
            pend_q    <= pend_d;
            pcnt_q    <= pcnt_d;
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
            ack_q     <= req;
            rdat_q    <= rdat_d;
        end
    end

    assign o_pwm    = pwm_q;
    assign o_irq    = pend_q & ie_q;
    assign o_wb_ack = ack_q;
    assign o_wb_dat = rdat_q;

endmodule

// File: tb/tb_pwm_multi_wb.sv
// Bench for pwm_multi_wb: directed scenarios plus random bus traffic, every clock compared
// against a register-map level reference model held in this file.
module tb_pwm_multi_wb;

    localparam int NCH = 3;

    logic           clk, rst_n;
    logic [NCH-1:0] pwm;
    logic           irq;
    logic [31:0]    wb_adr, wb_dat, wb_rdat;
    logic [3:0]     wb_sel;
    logic           wb_we, wb_cyc, wb_stb, wb_ack;

    pwm_multi_wb #(.NUM_CH(NCH), .PWM_W(8), .PRESC_W(32)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .o_pwm     (pwm),
        .o_irq     (irq),
        .i_wb_adr  (wb_adr),
        .i_wb_dat  (wb_dat),
        .i_wb_sel  (wb_sel),
        .i_wb_we   (wb_we),
        .i_wb_cyc  (wb_cyc),
        .i_wb_stb  (wb_stb),
        .o_wb_dat  (wb_rdat),
        .o_wb_ack  (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the register map as a word array plus the counting state.
    logic [31:0]    m_reg [32];
    logic [7:0]     m_act [NCH];
    int unsigned    m_wait;
    int unsigned    m_cnt;
    logic [NCH-1:0] m_pwm;
    logic           m_ack;
    logic [31:0]    m_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_reg[k] = 32'd0;
        m_reg[2] = 32'hFF;
        for (int k = 0; k < NCH; k++) m_act[k] = 8'd0;
        m_wait = 0;
        m_cnt  = 0;
        m_pwm  = '0;
        m_ack  = 1'b0;
        m_dat  = 32'd0;
    endtask

    // One clock of the model, using the bus inputs present at the rising edge.
    task automatic model_clock();
        logic [4:0]  ix;
        logic        rq, pe, en, inv;
        logic [31:0] wm, nv;
        ix  = wb_adr[6:2];
        rq  = wb_cyc && wb_stb && !m_ack;
        en  = m_reg[0][0];
        inv = m_reg[0][1];
        pe  = 1'b0;

        for (int ch = 0; ch < NCH; ch++)
            m_pwm[ch] = en ? ((m_cnt < 32'(m_act[ch])) ^ inv) : inv;

        m_ack = rq;
        if (rq) m_dat = (ix < 5'(4 + NCH)) ? m_reg[ix] : 32'd0;

        if (!en) begin
            m_wait = 0;
            m_cnt  = 0;
        end else if (m_wait == 0) begin
            m_wait = m_reg[1];
            if (m_cnt >= m_reg[2]) begin
                m_cnt = 0;
                pe    = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_wait = m_wait - 1;
        end

        if (pe && (m_reg[0][3] || m_reg[0][4])) begin
            for (int ch = 0; ch < NCH; ch++) m_act[ch] = m_reg[4 + ch][7:0];
            m_reg[0][4] = 1'b0;
        end

        if (rq && wb_we) begin
            wm = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
            nv = (m_reg[ix] & ~wm) | (wb_dat & wm);
            case (ix)
                5'd0: m_reg[0] = {27'd0, m_reg[0][4] | (wb_sel[0] & wb_dat[4]), nv[3:0]};
                5'd1: m_reg[1] = nv;
                5'd2: m_reg[2] = nv & 32'hFF;
                5'd3: if (wb_sel[0] && wb_dat[0]) m_reg[3][0] = 1'b0;
                default: if (ix < 5'(4 + NCH)) m_reg[ix] = nv & 32'hFF;
            endcase
        end

        if (pe) begin
            m_reg[3][0]     = 1'b1;
            m_reg[3][31:16] = m_reg[3][31:16] + 16'd1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_clock();
        else model_reset();
        @(negedge clk);
        check("pwm", 32'(pwm), 32'(m_pwm));
        check("irq", 32'(irq), 32'(m_reg[3][0] & m_reg[0][2]));
        check("ack", 32'(wb_ack), 32'(m_ack));
        check("rdat", wb_rdat, m_dat);
    endtask

    task automatic wb_xfer(input logic [4:0] ix, input logic we, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
        int n;
        n      = 0;
        wb_adr = ($urandom() & 32'hFFFF_FF83) | {25'd0, ix, 2'b00};
        wb_we  = we;
        wb_dat = d;
        wb_sel = sel;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        do begin
            step();
            n++;
        end while (!wb_ack && n < 4);
        check("ack_timeout", 32'(wb_ack), 32'd1);
        rd     = wb_rdat;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] ix, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_xfer(ix, 1'b1, d, 4'hF, unused_rd);
    endtask

    task automatic rd(input logic [4:0] ix, output logic [31:0] r);
        wb_xfer(ix, 1'b0, 32'd0, 4'hF, r);
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step();
            hi += int'(pwm[ch]);
        end
    endtask

    task automatic wait_irq(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (irq) break;
            step();
        end
        check("irq_wait", 32'(irq), 32'd1);
    endtask

    initial begin
        logic [31:0] r, s0, s1, d;
        logic [4:0]  ix;
        logic [3:0]  sel;
        logic        we;
        int          hi;

        rst_n  = 1'b0;
        wb_adr = 32'd0;
        wb_dat = 32'd0;
        wb_sel = 4'd0;
        wb_we  = 1'b0;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_dat", wb_rdat, 32'd0);
        rst_n = 1'b1;

        // PRESC=0, TOP=9, DUTY0=3: 3 high clocks in any 10
        wr(5'd2, 32'd9);
        wr(5'd1, 32'd0);
        wr(5'd4, 32'd3);
        wr(5'd0, 32'h9);
        repeat (15) step();
        count_high(0, 10, hi);
        check("t1_duty3_of10", 32'(hi), 32'd3);

        // PRESC=3, TOP=3, DUTY1=2: 8 high / 8 low
        wr(5'd1, 32'd3);
        wr(5'd2, 32'd3);
        wr(5'd5, 32'd2);
        repeat (40) step();
        count_high(1, 16, hi);
        check("t2_ch1_8of16", 32'(hi), 32'd8);

        // Shadow write without load keeps the old duty; UPD applies it next period
        wr(5'd1, 32'd0);
        wr(5'd2, 32'd9);
        repeat (25) step();
        wr(5'd0, 32'h1);
        wr(5'd4, 32'd7);
        count_high(0, 20, hi);
        check("t3_no_upd_6of20", 32'(hi), 32'd6);
        rd(5'd0, r);
        check("t3_ctrl", r, 32'h1);
        rd(5'd4, r);
        check("t3_shadow_rd", r, 32'd7);
        wr(5'd0, 32'h11);
        repeat (15) step();
        rd(5'd0, r);
        check("t3_upd_cleared", r, 32'h1);
        count_high(0, 10, hi);
        check("t3_duty7_of10", 32'(hi), 32'd7);

        // INV=1, DUTY0=0 -> constant 1; DUTY1 > TOP -> constant 0
        wr(5'd4, 32'd0);
        wr(5'd5, 32'd255);
        wr(5'd2, 32'd254);
        wr(5'd0, 32'hB);
        repeat (300) step();
        count_high(0, 40, hi);
        check("t4_ch0_const1", 32'(hi), 32'd40);
        count_high(1, 260, hi);
        check("t4_ch1_const0", 32'(hi), 32'd0);
        // DUTY1 == TOP == 255: output is INV only while the count sits at 255
        wr(5'd2, 32'd255);
        repeat (300) step();
        count_high(1, 256, hi);
        check("t4_top255_1of256", 32'(hi), 32'd1);

        // Interrupt, PEND clear and period count
        wr(5'd1, 32'd3);
        wr(5'd2, 32'd9);
        wr(5'd0, 32'hD);
        wr(5'd3, 32'd1);
        wait_irq(200);
        wr(5'd3, 32'd1);
        check("t5_irq_low_after_clr", 32'(irq), 32'd0);
        rd(5'd3, s0);
        check("t5_pend_clr", 32'(s0[0]), 32'd0);
        wait_irq(100);
        rd(5'd3, s1);
        check("t5_pend_set", 32'(s1[0]), 32'd1);
        check("t5_pcnt_inc", 32'(s1[31:16]), 32'(s0[31:16] + 16'd1));
        wr(5'd3, 32'd1);
        check("t5_irq_low_again", 32'(irq), 32'd0);

        // Back-to-back requests: ack every other cycle
        wb_adr = 32'h8;
        wb_we  = 1'b0;
        wb_sel = 4'hF;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            hi += int'(wb_ack);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        check("t6_b2b_acks", 32'(hi), 32'd3);

        // Unmapped words and byte lanes
        wr(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, r);
        check("t7_unmapped", r, 32'd0);
        wr(5'd7, 32'hFFFF_FFFF);
        rd(5'd7, r);
        check("t7_past_last_ch", r, 32'd0);
        wb_xfer(5'd2, 1'b1, 32'h0000_0055, 4'b0000, r);
        rd(5'd2, r);
        check("t7_sel_none", r, 32'd9);
        wb_xfer(5'd1, 1'b1, 32'h0000_0702, 4'b0001, r);
        rd(5'd1, r);
        check("t7_sel_lane0", r, 32'd2);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            ix  = 5'($urandom_range(0, 9));
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom());
            case (ix)
                5'd0: begin
                    d = $urandom();
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                end
                5'd1:    d = 32'($urandom_range(0, 3));
                5'd2:    d = 32'($urandom_range(0, 15));
                5'd4, 5'd5, 5'd6: d = 32'($urandom_range(0, 18));
                default: d = $urandom();
            endcase
            wb_xfer(ix, we, d, sel, r);
            repeat ($urandom_range(0, 3)) step();
        end

        // Reset asserted mid-period while running
        wr(5'd0, 32'hB);
        repeat (7) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_pwm", 32'(pwm), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        check("rst_mid_ack", 32'(wb_ack), 32'd0);
        check("rst_mid_dat", wb_rdat, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 4 + NCH; k++) begin
            rd(5'(k), r);
            check($sformatf("rst_reg%0d", k), r, (k == 2) ? 32'hFF : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
